// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker for decode: stalls on RAW/WAW against results not yet
// bypassable and flags sources that must be taken from the bypass network.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [$clog2(NUM_REGS)-1:0] dec_src1,
  input  logic [$clog2(NUM_REGS)-1:0] dec_src2,
  input  logic [$clog2(NUM_REGS)-1:0] dec_dst,
  input  logic                        dec_use_src2,
  input  logic                        dec_we,
  input  logic                        issue_valid,
  input  logic [LAT_W-1:0]            issue_lat,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_dst,
  output logic                        stall_out,
  output logic                        src1_fwd,
  output logic                        src2_fwd,
  output logic                        issue_ack,
  output logic [CNT_W-1:0]            stall_cycles
);

  localparam int unsigned RW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [LAT_W-1:0]    cnt     [NUM_REGS];
  logic [LAT_W-1:0]    cnt_nxt [NUM_REGS];

  logic pend1, pend2, pendd;
  logic wait1, wait2, waitd;
  logic raw1, raw2, waw;

  // x0 is never pending, so it can neither stall nor forward
  assign pend1 = busy[dec_src1] && (dec_src1 != '0);
  assign pend2 = busy[dec_src2] && (dec_src2 != '0);
  assign pendd = busy[dec_dst]  && (dec_dst  != '0);

  assign wait1 = cnt[dec_src1] != '0;
  assign wait2 = cnt[dec_src2] != '0;
  assign waitd = cnt[dec_dst]  != '0;

  assign raw1 = pend1 && wait1;
  assign raw2 = dec_use_src2 && pend2 && wait2;
  assign waw  = dec_we && pendd && waitd;

  assign stall_out = issue_valid && (raw1 || raw2 || waw);
  assign issue_ack = issue_valid && !stall_out;
  assign src1_fwd  = pend1 && !wait1;
  assign src2_fwd  = dec_use_src2 && pend2 && !wait2;

  // Next entry state: flush, then countdown, then writeback retire, then new issue
  always_comb begin
    busy_nxt = busy;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
    end
    if (flush) begin
      busy_nxt = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_nxt[r] = '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (busy[r] && (cnt[r] != '0)) begin
          cnt_nxt[r] = cnt[r] - LAT_W'(1);
        end
      end
      if (wb_valid) begin
        busy_nxt[wb_dst] = 1'b0;
      end
      if (issue_ack && dec_we && (dec_dst != RW'(0))) begin
        busy_nxt[dec_dst] = 1'b1;
        cnt_nxt[dec_dst]  = issue_lat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      busy <= busy_nxt;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
    end
  end

  // Saturating stall counter; survives flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall_out && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
